// File: rtl/soc_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : soc_bus_arbiter
// Purpose  : Two-master, one-slave round-robin bus arbiter with a watchdog
//            timeout that answers with an error if the slave never acks.
// Revision : 1.0
// ============================================================================
module soc_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ack,
    output logic                m0_err,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ack,
    output logic                m1_err,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_req,
    output logic                s_we,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ack,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic                grant_id,
    output logic                busy
);

    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_last_grant;
    logic                r_grant;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [STRB_W-1:0]   r_wstrb;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_pick;

    // On a tie the master that did not win last time gets the bus.
    always_comb begin
        w_pick = 1'b0;
        if (m0_req && m1_req) begin
            w_pick = ~r_last_grant;
        end else if (m1_req) begin
            w_pick = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (m0_req || m1_req) begin
                        r_grant <= w_pick;
                        r_we    <= w_pick ? m1_we    : m0_we;
                        r_addr  <= w_pick ? m1_addr  : m0_addr;
                        r_wdata <= w_pick ? m1_wdata : m0_wdata;
                        r_wstrb <= w_pick ? m1_wstrb : m0_wstrb;
                        r_cnt   <= '0;
                        r_state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (s_ack) begin
                        r_rdata <= s_rdata;
                        r_err   <= 1'b0;
                        r_state <= S_RESP;
                    end else if ((TIMEOUT != 0) && (r_cnt == c_CNT_LAST)) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_last_grant <= r_grant;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Every output decodes flops only; no input reaches an output combinationally.
    assign s_req    = (r_state == S_BUSY);
    assign busy     = (r_state != S_IDLE);
    assign s_we     = r_we;
    assign s_addr   = r_addr;
    assign s_wdata  = r_wdata;
    assign s_wstrb  = r_wstrb;
    assign grant_id = r_grant;
    assign m0_ack   = (r_state == S_RESP) && !r_grant;
    assign m1_ack   = (r_state == S_RESP) &&  r_grant;
    assign m0_err   = m0_ack && r_err;
    assign m1_err   = m1_ack && r_err;
    assign m0_rdata = {DATA_W{m0_ack}} & r_rdata;
    assign m1_rdata = {DATA_W{m1_ack}} & r_rdata;

endmodule
`default_nettype wire

// File: doc/soc_bus_arbiter.md
Name: soc_bus_arbiter

Overview:
Two-master, one-slave arbiter for the SoC data bus. It shares a single memory/peripheral port between master 0 (core load/store unit) and master 1 (debug/program loader). Arbitration is round-robin, and a grant is held for one complete transaction. A watchdog timeout terminates a transaction when the slave never responds. The block sits between the core, the loader and the RAM/peripheral decoder inside open_risc_v_soc.

Parameters:
ADDR_W, 32, address width of masters and slave
DATA_W, 32, data width; must be a multiple of 8
TIMEOUT, 16, maximum cycles in BUSY before forced error response; 0 disables the timeout

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous reset, active high
m0_req  input  1  master 0 request; held until m0_ack
m0_we  input  1  master 0 write enable (1 = write, 0 = read)
m0_addr  input  ADDR_W  master 0 address
m0_wdata  input  DATA_W  master 0 write data
m0_wstrb  input  DATA_W/8  master 0 byte strobes
m0_ack  output  1  master 0 one-cycle completion pulse
m0_err  output  1  master 0 error flag, valid with m0_ack
m0_rdata  output  DATA_W  master 0 read data, valid with m0_ack
m1_*  (same set as m0_*)  master 1
s_req  output  1  slave request
s_we  output  1  slave write enable
s_addr  output  ADDR_W  slave address
s_wdata  output  DATA_W  slave write data
s_wstrb  output  DATA_W/8  slave byte strobes
s_ack  input  1  slave completion pulse
s_rdata  input  DATA_W  slave read data, valid with s_ack
grant_id  output  1  master currently owning the bus
busy  output  1  high whenever state is not IDLE

Behaviour:
- Clock and reset: single clock clk. rst is synchronous, active high.
- Reset values: state = IDLE; s_req = 0; all s_* buses = 0; m0/m1 ack = 0, err = 0, rdata = 0; grant_id = 0; busy = 0; last_grant = 1, so m0 wins the first tie.
- States: IDLE, BUSY, RESP.
- IDLE:
  - Sample m0_req and m1_req.
  - Only one request present: grant that master.
  - Both present: grant the master != last_grant.
  - None present: stay in IDLE.
  - On a grant, register the winner's we/addr/wdata/wstrb into the s_* output registers, set grant_id, clear the timeout counter, and go to BUSY.
- BUSY:
  - s_req = 1. s_* outputs stay constant, taken from the captured copy, so master input changes during BUSY have no effect.
  - On s_ack: latch s_rdata (writes still latch it; the value is don't-care to the master), err = 0, go to RESP.
  - Without s_ack: increment the counter. When TIMEOUT != 0 and the counter reaches TIMEOUT-1, go to RESP with err = 1 and rdata = 0.
  - s_req deasserts on the cycle the state leaves BUSY.
- RESP:
  - Exactly one cycle. Assert ack (with err and rdata) only to grant_id; the other master's ack stays 0.
  - Update last_grant = grant_id. Next state is IDLE.
- Master protocol:
  - A master keeps req and its attributes stable until it sees ack.
  - A master may keep req high through the RESP cycle to issue a back-to-back request; that request is sampled in the following IDLE cycle.
- Latency: req seen in IDLE at cycle N; s_req rises at N+1; s_ack at cycle K (K >= N+1) gives master ack at K+1.
  - Minimum cost is 3 cycles per transaction, for a slave that acks in its first BUSY cycle.
- Fairness: with both masters requesting continuously, grants strictly alternate 0,1,0,1...
- A stray s_ack in IDLE or RESP is ignored and changes no state or output.
- A requester dropping req mid-transaction is illegal. The transaction still completes and the ack is still issued.
- rst asserted in any state: on the next edge the FSM returns to IDLE, s_req drops, pending acks are cancelled and last_grant resets to 1.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
- Single read: after reset, m0 reads addr 0x10 and the slave acks in the first BUSY cycle with 0xDEADBEEF -> s_req is high for 1 cycle with s_addr=0x10, s_we=0; m0_ack pulses 3 cycles after req with m0_rdata=0xDEADBEEF, m0_err=0; m1_ack stays 0.
- Tie and round-robin: m0 and m1 both request continuously, 4 transactions, slave acks after 2 BUSY cycles -> grant_id sequence 0,1,0,1; each ack arrives 4 cycles after its IDLE sample; s_addr matches the granted master.
- Write with strobes: m1 writes 0x12345678 to 0x20 with wstrb=4'b0011 -> s_we=1, s_wdata=0x12345678, s_wstrb=0011 held stable while s_req=1; m1_ack pulses with m1_err=0.
- Timeout: TIMEOUT=16, slave never acks -> s_req is high for exactly 16 cycles, then m0_ack=1, m0_err=1, m0_rdata=0. A late s_ack injected 2 cycles later produces no ack and no state change.
- Reset mid-transaction: rst is asserted for 1 cycle during BUSY -> next cycle s_req=0, busy=0, no ack ever issued; a subsequent simultaneous m0/m1 request is granted to m0.
- Attribute isolation: m0 changes m0_addr from 0x40 to 0x80 during BUSY -> s_addr remains 0x40 until the transaction completes.
